lut_eval_stream: RTL and testbench
==================================

# lut_eval_stream

Parametrised, runtime-programmable truth-table evaluator, the successor to the fixed 3-input gate blocks. The block evaluates an N_IN-input Boolean function against a 2^N_IN-bit truth table. Input vectors arrive on a valid/ready stream, and results leave through a registered, back-pressurable output. A serial configuration port replaces the truth table at runtime; the new table commits atomically, so the netlist synthesizer can retarget one gate instance without rebuilding the design.

## Interface
Parameters:
- N_IN, 3: number of function inputs; legal range 1..8.
- TT_INIT, 8'hA0: truth table loaded at reset, 2^N_IN bits wide; bit i is the output for input vector i. The default gives out=1 only for vectors 3'b101 and 3'b111.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  in_data holds a vector to evaluate.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  N_IN  input vector; bit 0 corresponds to in1.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  1  evaluated function value.
- cfg_start  input  1  one-cycle pulse; begins a new table load and discards any partial load.
- cfg_valid  input  1  cfg_bit holds a valid configuration bit.
- cfg_bit  input  1  truth-table bit; bits arrive LSB first (bit 0 first).
- cfg_busy  output  1  a load is in progress (LOAD or COMMIT state).
- cfg_done  output  1  one-cycle pulse when the new table becomes active.

## Operation
- Evaluation path:
  - A transfer occurs when in_valid && in_ready.
  - On transfer, out_data is set to table[in_data] and out_valid is set to 1.
  - in_ready = !out_valid || out_ready, so throughput is one result per cycle.
  - The output register holds out_data and out_valid stable until out_valid && out_ready.
  - Accept and drain in the same cycle are legal; in that case out_valid stays 1 and out_data takes the new result.
- Configuration FSM, with states IDLE, LOAD and COMMIT:
  - IDLE -> LOAD on cfg_start. The bit counter and shadow register are cleared.
  - In LOAD, each cycle with cfg_valid=1 writes shadow[count] = cfg_bit and increments count. cfg_valid=0 stalls the load with no timeout.
  - LOAD -> COMMIT when the bit written at count = 2^N_IN-1 is accepted.
  - COMMIT -> IDLE after one cycle. In that cycle, table <= shadow and cfg_done = 1.
  - cfg_start in LOAD or COMMIT restarts the load: the count returns to 0 and the shadow is cleared. A cfg_start in COMMIT cancels that commit.
  - cfg_valid is ignored in IDLE and COMMIT.
  - cfg_busy = 1 in LOAD and COMMIT.
- The active table never holds a partially loaded value.
- Arithmetic and widths:
  - The bit counter is N_IN+1 bits wide and saturates (no wrap); it is not used after the terminal bit.
  - Table and shadow registers are 2^N_IN bits wide.
  - in_data indexes the table directly, so it needs no bounds check.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_data = 0.
  - cfg_busy = 0, cfg_done = 0.
  - table = TT_INIT, shadow = 0, FSM = IDLE, count = 0.
- Latency: a result appears 1 cycle after the input transfer.
- Table update:
  - The new table is applied at the clock edge ending the COMMIT cycle.
  - A vector accepted in the COMMIT cycle uses the old table.
  - A vector accepted in the following cycle uses the new table.
- Evaluation is never stalled by configuration.
- Reset mid-load: the block returns immediately to its reset values and the partial shadow is lost. Reset while out_valid is high drops the pending result.
- cfg_start and the terminal cfg_valid in the same cycle: cfg_start wins, the count goes to 0 and that bit is discarded.

## Structure
- Shared package lut_pkg holds:
  - cfg_state_t, an enum of IDLE, LOAD and COMMIT;
  - localparam function tt_width(n) = 1 << n;
  - constant N_IN_MAX = 8.
- Sub-module lut_cfg_loader contains the FSM, bit counter and shadow register. It outputs shadow, a commit strobe, cfg_busy and cfg_done.
- The top level holds the active table and the evaluation output register.

## Test plan
- Reset release, then vectors 3'b000..3'b111 streamed with out_ready=1 -> out_data sequence 0,0,0,0,0,1,0,1, each result 1 cycle after its input.
- Load 8'h80 (bit7 = 1, all other bits 0), then evaluate 3'b101 and 3'b111 -> 0 then 1. cfg_done pulses exactly once, and cfg_busy is high for 9 cycles when cfg_valid is held high.
- Hold out_ready=0 with in_valid=1 -> in_ready drops after the first accept, and out_data stays stable. Release out_ready -> no vector lost or duplicated.
- Accept a vector in the COMMIT cycle, and another vector one cycle later, while loading 8'hFF -> results are old-table then new-table (3'b000 -> 0 then 1).
- Assert rst_n=0 after 4 of 8 load bits, then evaluate 3'b101 -> 1 (TT_INIT still active); cfg_busy=0.
- Pulse cfg_start mid-load, then load 8'h01 completely -> only 3'b000 evaluates to 1, and the restart discarded the earlier partial bits.

Source files
------------

// File: rtl/lut_pkg.sv
// lut_pkg: shared types and sizing helpers for the truth-table evaluator
package lut_pkg;

    localparam int N_IN_MAX = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/lut_eval_stream_if.sv
// lut_eval_stream_if: input-vector stream and registered result stream
interface lut_eval_stream_if #(parameter int N_IN = 3);

    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: serial truth-table loader with atomic commit strobe
module lut_cfg_loader
    import lut_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_start,
    input  logic                      cfg_valid,
    input  logic                      cfg_bit,
    output logic [tt_width(N_IN)-1:0] o_shadow,
    output logic                      o_commit,
    output logic                      cfg_busy,
    output logic                      cfg_done
);

    localparam int TW = tt_width(N_IN);
    localparam logic [N_IN:0] LAST = (N_IN+1)'(TW - 1);

    cfg_state_t      r_state;
    cfg_state_t      w_next;
    logic [N_IN:0]   r_cnt;
    logic [TW-1:0]   r_shadow;
    logic            w_last;

    assign w_last   = cfg_valid && (r_cnt == LAST);
    assign o_shadow = r_shadow;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state and strobes; a start in COMMIT cancels the commit
    always_comb begin
        w_next   = r_state;
        o_commit = 1'b0;
        cfg_done = 1'b0;
        cfg_busy = r_state != IDLE;
        case (r_state)
            IDLE:    w_next = cfg_start ? LOAD : IDLE;
            LOAD:    w_next = (!cfg_start && w_last) ? COMMIT : LOAD;
            COMMIT: begin
                w_next   = cfg_start ? LOAD : IDLE;
                o_commit = !cfg_start;
                cfg_done = !cfg_start;
            end
            default: w_next = IDLE;
        endcase
    end

    // bit counter and shadow; start wins over a same-cycle bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_shadow <= '0;
        end else if (cfg_start) begin
            r_cnt    <= '0;
            r_shadow <= '0;
        end else if (r_state == LOAD && cfg_valid) begin
            r_shadow[r_cnt[N_IN-1:0]] <= cfg_bit;
            r_cnt <= r_cnt[N_IN] ? r_cnt : r_cnt + (N_IN+1)'(1);
        end
    end

endmodule

// File: rtl/lut_eval_stream.sv
// lut_eval_stream: runtime-programmable N-input truth-table evaluator
module lut_eval_stream
    import lut_pkg::*;
#(
    parameter int                      N_IN    = 3,
    parameter logic [tt_width(N_IN)-1:0] TT_INIT = (tt_width(N_IN))'(8'hA0)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lut_eval_stream_if.slave       s,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    input  logic                   cfg_bit,
    output logic                   cfg_busy,
    output logic                   cfg_done
);

    localparam int TW = tt_width(N_IN);

    logic [TW-1:0] r_table;
    logic [TW-1:0] w_shadow;
    logic          w_commit;
    logic          w_accept;
    logic          r_out_valid;
    logic          r_out_data;

    lut_cfg_loader #(.N_IN(N_IN)) u_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .o_shadow  (w_shadow),
        .o_commit  (w_commit),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done)
    );

    assign s.in_ready  = !r_out_valid || s.out_ready;
    assign w_accept    = s.in_valid && s.in_ready;
    assign s.out_valid = r_out_valid;
    assign s.out_data  = r_out_data;

    // active table swaps only on a full, uncancelled commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_table <= TT_INIT;
        else if (w_commit) r_table <= w_shadow;
    end

    // output register: load on accept, hold until drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_table[s.in_data];
        end else if (s.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lut_eval_stream.sv
// tb_lut_eval_stream: randomized and directed checks against a queue-based reference
module tb_lut_eval_stream;

    logic clk = 1'b0;
    logic rst_n;
    logic cfg_start, cfg_valid, cfg_bit;
    logic cfg_busy, cfg_done;

    int n_cmp = 0;
    int n_bad = 0;
    int n_busy = 0;
    int n_done = 0;

    logic [7:0] m_tt;
    bit         m_cfg_q[$];
    bit         m_loading;
    bit         m_commit;
    bit         m_out[$];

    lut_eval_stream_if #(.N_IN(3)) bus ();

    lut_eval_stream #(.N_IN(3), .TT_INIT(8'hA0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (bus),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tt = 8'hA0;
        m_cfg_q.delete();
        m_loading = 0;
        m_commit = 0;
        m_out.delete();
    endtask

    // predict the effect of the coming rising edge from the driven inputs
    task automatic model_edge();
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = bus.in_valid && (m_out.size() == 0 || bus.out_ready);
        if (m_out.size() > 0 && bus.out_ready) void'(m_out.pop_front());
        if (acc) m_out.push_back(m_tt[bus.in_data]);
        if (cfg_start) begin
            m_loading = 1;
            m_commit = 0;
            m_cfg_q.delete();
        end else if (m_commit) begin
            for (int i = 0; i < 8; i++) m_tt[i] = m_cfg_q[i];
            m_commit = 0;
        end else if (m_loading && cfg_valid) begin
            m_cfg_q.push_back(cfg_bit);
            if (m_cfg_q.size() == 8) begin
                m_loading = 0;
                m_commit = 1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("in_ready", bus.in_ready, m_out.size() == 0 || bus.out_ready);
        check("out_valid", bus.out_valid, m_out.size() != 0);
        if (m_out.size() != 0) check("out_data", bus.out_data, m_out[0]);
        check("cfg_busy", cfg_busy, m_loading || m_commit);
        check("cfg_done", cfg_done, m_commit && !cfg_start);
        if (cfg_busy) n_busy++;
        if (cfg_done) n_done++;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v, input int n);
        cfg_start = 1;
        step();
        cfg_start = 0;
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1;
            cfg_bit = v[i];
            step();
        end
        cfg_valid = 0;
        cfg_bit = 0;
    endtask

    task automatic eval(input logic [2:0] v, input logic exp, input string tag);
        bus.in_valid = 1;
        bus.in_data = v;
        step();
        bus.in_valid = 0;
        check(tag, bus.out_data, exp);
    endtask

    initial begin
        logic [7:0] exp_a0;
        int acc_cnt;
        exp_a0 = 8'hA0;
        rst_n = 0;
        cfg_start = 0;
        cfg_valid = 0;
        cfg_bit = 0;
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.out_ready = 1;
        model_reset();
        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_done", cfg_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        step();

        for (int v = 0; v < 8; v++) eval(3'(v), exp_a0[v], "stream_a0");
        step();

        n_busy = 0;
        n_done = 0;
        load(8'h80, 8);
        step();
        step();
        check("busy_cycles", n_busy, 9);
        check("done_pulses", n_done, 1);
        eval(3'b101, 0, "tt80_101");
        eval(3'b111, 1, "tt80_111");
        step();

        bus.out_ready = 0;
        bus.in_valid = 1;
        bus.in_data = 3'b111;
        step();
        bus.in_data = 3'b000;
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_hold", bus.out_data, 1);
        end
        bus.out_ready = 1;
        step();
        bus.in_valid = 0;
        check("bp_next", bus.out_data, 0);
        step();
        check("bp_drained", bus.out_valid, 0);

        load(8'hFF, 8);
        eval(3'b000, 0, "commit_old");
        eval(3'b000, 1, "commit_new");
        step();

        rst_n = 1;
        load(8'h80, 8);
        step();
        load(8'h00, 4);
        rst_n = 0;
        model_reset();
        #1;
        check("midrst_busy", cfg_busy, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        step();
        eval(3'b101, 1, "midrst_101");
        step();
        check("midrst_busy_idle", cfg_busy, 0);

        load(8'hFE, 3);
        load(8'h01, 8);
        step();
        for (int v = 0; v < 8; v++) eval(3'(v), v == 0, "restart_tt01");
        step();

        for (int i = 0; i < 3000; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_data = 3'($urandom);
            bus.out_ready = ($urandom % 4) != 0;
            cfg_start = ($urandom % 30) == 0;
            cfg_valid = 1'($urandom);
            cfg_bit = 1'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
